pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WD, default 32: PC and address width.
REQ-002 Parameter DIV_TIMEOUT, default 64: maximum BUSY cycles before forced abort.
REQ-003 clk  in  1  Single clock; all state updates on its rising edge.
REQ-004 rest  in  1  Reset, synchronous, active-high.
REQ-005 ex_load_i  in  1  Instruction in EX is a load.
REQ-006 ex_rd_i  in  5  EX destination register.
REQ-007 id_rs1_i, id_rs2_i  in  5 each  ID source registers.
REQ-008 id_rs1_use_i, id_rs2_use_i  in  1 each  ID actually reads rs1 / rs2.
REQ-009 ex_jump_i  in  1  Branch taken or jump resolved in EX.
REQ-010 ex_jump_addr_i  in  WD  Jump target.
REQ-011 div_start_i  in  1  Multi-cycle op entering EX.
REQ-012 div_done_i  in  1  Multi-cycle op result valid.
REQ-013 trap_req_i  in  1  Exception or interrupt accepted.
REQ-014 trap_vec_i  in  WD  Trap handler address.
REQ-015 hold_pc_o, hold_ifid_o, hold_idex_o  out  1 each  Stage register keeps its value.
REQ-016 flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o  out  1 each  Refresh flag into the pipeline DFF: load default value (bubble).
REQ-017 redirect_o  out  1; redirect_addr_o  out  WD  PC redirect request and target.
REQ-018 div_abort_o  out  1  One-cycle pulse on timeout.
REQ-019 stall_cnt_o  out  32  Count of cycles with hold_pc_o high.

Function
REQ-020 FSM states RUN, BUSY, DRAIN; held in a register; all outputs except stall_cnt_o are combinational from state and inputs.
REQ-021 Priority within a cycle: trap > jump > div_start > load-use.
REQ-022 Load-use hazard (RUN only): ex_load_i=1, ex_rd_i!=0, and (ex_rd_i==id_rs1_i with id_rs1_use_i) or (ex_rd_i==id_rs2_i with id_rs2_use_i) -> hold_pc_o=hold_ifid_o=1, flush_idex_o=1; exactly one bubble per hazard instance.
REQ-023 Jump (RUN): ex_jump_i=1 -> flush_ifid_o=flush_idex_o=1, redirect_o=1, redirect_addr_o=ex_jump_addr_i; load-use suppressed that cycle.
REQ-024 RUN with div_start_i=1 and no trap/jump -> next state BUSY; busy counter cleared to 0.
REQ-025 BUSY: hold_pc_o=hold_ifid_o=hold_idex_o=1, flush_exmem_o=1; busy counter increments each cycle.
REQ-026 BUSY with div_done_i=1 -> holds deasserted that cycle, next state RUN.
REQ-027 BUSY with busy counter == DIV_TIMEOUT-1 and div_done_i=0 -> div_abort_o=1 for one cycle, next state RUN.
REQ-028 Trap in RUN or BUSY: all four flush outputs =1, redirect_o=1, redirect_addr_o=trap_vec_i, next state DRAIN; any pending BUSY is abandoned.
REQ-029 DRAIN lasts exactly one cycle: flush_ifid_o=1, all other outputs 0; trap_req_i, ex_jump_i and div_start_i are ignored; next state RUN.
REQ-030 div_done_i outside BUSY is ignored; div_start_i while in BUSY is ignored.
REQ-031 stall_cnt_o increments by 1 every cycle hold_pc_o=1 and wraps 0xFFFFFFFF -> 0.
REQ-032 With no events in RUN, all hold, flush, redirect and abort outputs are 0.

Reset
REQ-033 While rest=1: state RUN, busy counter 0, stall_cnt_o 0; all four flush outputs 1; hold, redirect and abort outputs 0; redirect_addr_o 0.
REQ-034 Reset asserted in BUSY or DRAIN returns the FSM to RUN at the next edge, with no div_abort_o pulse.

Verification
REQ-035 Load-use: ex_load_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_use_i=1 -> one cycle hold_pc_o=hold_ifid_o=flush_idex_o=1; stall_cnt_o +1. Same inputs with ex_rd_i=0 -> no stall.
REQ-036 Jump and hazard in the same cycle, ex_jump_addr_i=0x80 -> redirect_o=1, redirect_addr_o=0x80, flush_ifid_o=flush_idex_o=1, hold_pc_o=0.
REQ-037 div_start_i, then div_done_i 10 cycles later -> 10 BUSY cycles with holds and flush_exmem_o=1, then RUN; stall_cnt_o=10.
REQ-038 div_start_i with div_done_i never asserted -> div_abort_o pulses after exactly 64 BUSY cycles, then RUN.
REQ-039 trap_req_i in BUSY, trap_vec_i=0x100 -> all flushes and redirect to 0x100; one DRAIN cycle, during which a second trap_req_i is ignored; then RUN.
REQ-040 rest pulsed in BUSY -> next cycle state RUN, all counters 0, no abort pulse.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- signal bundle between the pipeline datapath and pipe_ctrl.
//   master : pipeline side; drives hazard/jump/div/trap status, receives
//            hold/flush/redirect/abort controls and the stall counter.
//   slave  : pipe_ctrl side.
//   WD     : PC / address width.
interface pipe_ctrl_if #(
   parameter int WD = 32
);
   // status from the datapath
   logic          ex_load_i;
   logic [4:0]    ex_rd_i;
   logic [4:0]    id_rs1_i;
   logic [4:0]    id_rs2_i;
   logic          id_rs1_use_i;
   logic          id_rs2_use_i;
   logic          ex_jump_i;
   logic [WD-1:0] ex_jump_addr_i;
   logic          div_start_i;
   logic          div_done_i;
   logic          trap_req_i;
   logic [WD-1:0] trap_vec_i;

   // controls back to the datapath
   logic          hold_pc_o;
   logic          hold_ifid_o;
   logic          hold_idex_o;
   logic          flush_ifid_o;
   logic          flush_idex_o;
   logic          flush_exmem_o;
   logic          flush_memwb_o;
   logic          redirect_o;
   logic [WD-1:0] redirect_addr_o;
   logic          div_abort_o;
   logic [31:0]   stall_cnt_o;

   modport master (
      output ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
             ex_jump_i, ex_jump_addr_i, div_start_i, div_done_i, trap_req_i, trap_vec_i,
      input  hold_pc_o, hold_ifid_o, hold_idex_o,
             flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o,
             redirect_o, redirect_addr_o, div_abort_o, stall_cnt_o
   );

   modport slave (
      input  ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
             ex_jump_i, ex_jump_addr_i, div_start_i, div_done_i, trap_req_i, trap_vec_i,
      output hold_pc_o, hold_ifid_o, hold_idex_o,
             flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o,
             redirect_o, redirect_addr_o, div_abort_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- in-order pipeline hazard / redirect controller.
//   clk  : single clock, rising edge
//   rest : synchronous active-high reset
//   bus  : pipe_ctrl_if.slave (load-use, jump, multi-cycle op, trap inputs;
//          hold/flush/redirect/abort outputs, stall cycle counter)
// FSM RUN / BUSY / DRAIN in registers; every control output except the stall
// counter is decoded combinationally from state, reset and inputs.
// Priority inside a cycle: trap > jump > div_start > load-use.
module pipe_ctrl #(
   parameter int WD          = 32,
   parameter int DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rest,
   pipe_ctrl_if.slave  bus
);

   localparam int CW = $clog2(DIV_TIMEOUT + 1);
   localparam logic [CW-1:0] BUSY_LAST = CW'(DIV_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, BUSY, DRAIN} state_t;

   state_t        state;
   logic [CW-1:0] busy_cnt;
   logic [31:0]   stall_cnt;
   logic          lu_block;   // a load-use bubble was inserted last cycle
   logic          lu_raw;
   logic          lu_stall;

   // Raw RAW-after-load detect; x0 never creates a dependency.
   assign lu_raw = bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                   (((bus.ex_rd_i == bus.id_rs1_i) && bus.id_rs1_use_i) ||
                    ((bus.ex_rd_i == bus.id_rs2_i) && bus.id_rs2_use_i));

   // lu_block limits each hazard to a single bubble even if the EX status
   // does not change in the cycle right after the stall.
   assign lu_stall = !rest && (state == RUN) && !bus.trap_req_i && !bus.ex_jump_i &&
                     !bus.div_start_i && lu_raw && !lu_block;

   always_comb begin
      bus.hold_pc_o       = 1'b0;
      bus.hold_ifid_o     = 1'b0;
      bus.hold_idex_o     = 1'b0;
      bus.flush_ifid_o    = 1'b0;
      bus.flush_idex_o    = 1'b0;
      bus.flush_exmem_o   = 1'b0;
      bus.flush_memwb_o   = 1'b0;
      bus.redirect_o      = 1'b0;
      bus.redirect_addr_o = {WD{1'b0}};
      bus.div_abort_o     = 1'b0;
      if (rest) begin
         // reset fills every stage with bubbles
         bus.flush_ifid_o  = 1'b1;
         bus.flush_idex_o  = 1'b1;
         bus.flush_exmem_o = 1'b1;
         bus.flush_memwb_o = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (bus.trap_req_i) begin
                  bus.flush_ifid_o    = 1'b1;
                  bus.flush_idex_o    = 1'b1;
                  bus.flush_exmem_o   = 1'b1;
                  bus.flush_memwb_o   = 1'b1;
                  bus.redirect_o      = 1'b1;
                  bus.redirect_addr_o = bus.trap_vec_i;
               end else if (bus.ex_jump_i) begin
                  bus.flush_ifid_o    = 1'b1;
                  bus.flush_idex_o    = 1'b1;
                  bus.redirect_o      = 1'b1;
                  bus.redirect_addr_o = bus.ex_jump_addr_i;
               end else if (lu_stall) begin
                  bus.hold_pc_o    = 1'b1;
                  bus.hold_ifid_o  = 1'b1;
                  bus.flush_idex_o = 1'b1;
               end
            end
            BUSY: begin
               if (bus.trap_req_i) begin
                  bus.flush_ifid_o    = 1'b1;
                  bus.flush_idex_o    = 1'b1;
                  bus.flush_exmem_o   = 1'b1;
                  bus.flush_memwb_o   = 1'b1;
                  bus.redirect_o      = 1'b1;
                  bus.redirect_addr_o = bus.trap_vec_i;
               end else if (!bus.div_done_i) begin
                  // op still running: freeze front end, bubble into MEM
                  bus.hold_pc_o     = 1'b1;
                  bus.hold_ifid_o   = 1'b1;
                  bus.hold_idex_o   = 1'b1;
                  bus.flush_exmem_o = 1'b1;
                  bus.div_abort_o   = (busy_cnt == BUSY_LAST);
               end
            end
            DRAIN: bus.flush_ifid_o = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         state     <= RUN;
         busy_cnt  <= '0;
         stall_cnt <= '0;
         lu_block  <= 1'b0;
      end else begin
         stall_cnt <= stall_cnt + {31'd0, bus.hold_pc_o};  // wraps naturally
         lu_block  <= lu_stall;
         unique case (state)
            RUN: begin
               if (bus.trap_req_i) begin
                  state <= DRAIN;
               end else if (!bus.ex_jump_i && bus.div_start_i) begin
                  state    <= BUSY;
                  busy_cnt <= '0;
               end
            end
            BUSY: begin
               if (bus.trap_req_i)                state <= DRAIN;
               else if (bus.div_done_i)           state <= RUN;
               else if (busy_cnt == BUSY_LAST)    state <= RUN;
               else                               busy_cnt <= busy_cnt + CW'(1);
            end
            DRAIN:   state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later, stall_cnt_o after the following edge.
module tb_pipe_ctrl;
   logic clk;
   logic rest;
   int   n_total;
   int   n_pass;

   pipe_ctrl_if #(.WD(32)) bus ();

   pipe_ctrl #(.WD(32), .DIV_TIMEOUT(64)) dut (
      .clk  (clk),
      .rest (rest),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // holds {pc,ifid,idex}, flushes {ifid,idex,exmem,memwb}, redirect, abort
   task automatic chk_out(input string tag, input logic [2:0] h, input logic [3:0] f,
                          input logic r, input logic a);
      chk(tag, {55'd0, bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idex_o,
                bus.flush_ifid_o, bus.flush_idex_o, bus.flush_exmem_o, bus.flush_memwb_o,
                bus.redirect_o, bus.div_abort_o},
          {55'd0, h, f, r, a});
   endtask

   task automatic idle();
      bus.ex_load_i = 0; bus.ex_rd_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0;
      bus.id_rs1_use_i = 0; bus.id_rs2_use_i = 0; bus.ex_jump_i = 0;
      bus.ex_jump_addr_i = 0; bus.div_start_i = 0; bus.div_done_i = 0;
      bus.trap_req_i = 0; bus.trap_vec_i = 0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      n_total = 0; n_pass = 0;
      idle();
      rest = 1'b1;
      // reset state; a trap during reset must not redirect
      cyc();
      bus.trap_req_i = 1; bus.trap_vec_i = 32'h44;
      #1;
      chk_out("reset_outs", 3'b000, 4'b1111, 0, 0);
      chk("reset_addr", {32'd0, bus.redirect_addr_o}, 64'd0);
      cyc();
      chk("reset_stall", {32'd0, bus.stall_cnt_o}, 64'd0);
      idle(); rest = 1'b0;
      #1;
      chk_out("run_idle", 3'b000, 4'b0000, 0, 0);
      cyc();

      // load-use via rs1: one bubble only
      bus.ex_load_i = 1; bus.ex_rd_i = 5; bus.id_rs1_i = 5; bus.id_rs1_use_i = 1;
      #1;
      chk_out("lu_rs1", 3'b110, 4'b0100, 0, 0);
      cyc();
      chk("lu_stall1", {32'd0, bus.stall_cnt_o}, 64'd1);
      chk_out("lu_one_bubble", 3'b000, 4'b0000, 0, 0);
      cyc();
      // rd = x0 never stalls
      bus.ex_rd_i = 0; bus.id_rs1_i = 0;
      #1;
      chk_out("lu_x0", 3'b000, 4'b0000, 0, 0);
      cyc();
      // rs2 path
      bus.ex_rd_i = 7; bus.id_rs2_i = 7; bus.id_rs2_use_i = 1; bus.id_rs1_use_i = 0;
      #1;
      chk_out("lu_rs2", 3'b110, 4'b0100, 0, 0);
      cyc();
      chk("lu_stall2", {32'd0, bus.stall_cnt_o}, 64'd2);
      idle();
      cyc();
      // rs2 matches but not used
      bus.ex_load_i = 1; bus.ex_rd_i = 7; bus.id_rs2_i = 7; bus.id_rs2_use_i = 0;
      #1;
      chk_out("lu_unused", 3'b000, 4'b0000, 0, 0);
      cyc();

      // jump beats load-use
      bus.ex_load_i = 1; bus.ex_rd_i = 5; bus.id_rs1_i = 5; bus.id_rs1_use_i = 1;
      bus.ex_jump_i = 1; bus.ex_jump_addr_i = 32'h80;
      #1;
      chk_out("jump_lu", 3'b000, 4'b1100, 1, 0);
      chk("jump_addr", {32'd0, bus.redirect_addr_o}, 64'h80);
      cyc();
      idle();
      // div_done outside BUSY is ignored
      bus.div_done_i = 1;
      #1;
      chk_out("done_in_run", 3'b000, 4'b0000, 0, 0);
      cyc();
      chk("stall_after_jump", {32'd0, bus.stall_cnt_o}, 64'd2);

      // multi-cycle op completing after 10 hold cycles
      idle(); bus.div_start_i = 1;
      #1;
      chk_out("div_start", 3'b000, 4'b0000, 0, 0);
      cyc();
      bus.div_start_i = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk_out($sformatf("busy_%0d", i), 3'b111, 4'b0010, 0, 0);
         cyc();
      end
      bus.div_done_i = 1;
      #1;
      chk_out("div_done", 3'b000, 4'b0000, 0, 0);
      cyc();
      bus.div_done_i = 0;
      #1;
      chk_out("div_back_run", 3'b000, 4'b0000, 0, 0);
      chk("div_stall10", {32'd0, bus.stall_cnt_o}, 64'd12);

      // timeout: abort on the 64th BUSY cycle; div_start in BUSY ignored
      bus.div_start_i = 1;
      cyc();
      for (int i = 0; i < 64; i++) begin
         bus.div_start_i = (i < 63);
         #1;
         chk($sformatf("to_abort_%0d", i), {63'd0, bus.div_abort_o}, {63'd0, (i == 63)});
         cyc();
      end
      #1;
      chk_out("to_back_run", 3'b000, 4'b0000, 0, 0);
      chk("to_stall64", {32'd0, bus.stall_cnt_o}, 64'd76);

      // trap in BUSY, then DRAIN ignores trap/jump/start
      bus.div_start_i = 1;
      cyc();
      bus.div_start_i = 0;
      #1;
      chk_out("trap_pre_busy", 3'b111, 4'b0010, 0, 0);
      cyc();
      bus.trap_req_i = 1; bus.trap_vec_i = 32'h100;
      #1;
      chk_out("trap_busy", 3'b000, 4'b1111, 1, 0);
      chk("trap_addr", {32'd0, bus.redirect_addr_o}, 64'h100);
      cyc();
      bus.trap_vec_i = 32'h200; bus.ex_jump_i = 1; bus.ex_jump_addr_i = 32'h300;
      bus.div_start_i = 1;
      #1;
      chk_out("drain", 3'b000, 4'b1000, 0, 0);
      chk("drain_addr", {32'd0, bus.redirect_addr_o}, 64'd0);
      cyc();
      idle();
      #1;
      chk_out("drain_to_run", 3'b000, 4'b0000, 0, 0);
      chk("trap_stall", {32'd0, bus.stall_cnt_o}, 64'd77);

      // reset in BUSY right at the would-be abort cycle
      bus.div_start_i = 1;
      cyc();
      bus.div_start_i = 0;
      for (int i = 0; i < 63; i++) cyc();
      chk("rst_pre_stall", {32'd0, bus.stall_cnt_o}, 64'd140);
      rest = 1'b1;
      #1;
      chk_out("rst_in_busy", 3'b000, 4'b1111, 0, 0);
      cyc();
      rest = 1'b0;
      #1;
      chk_out("rst_run", 3'b000, 4'b0000, 0, 0);
      chk("rst_stall0", {32'd0, bus.stall_cnt_o}, 64'd0);
      cyc();
      // FSM is really in RUN: load-use stalls again
      bus.ex_load_i = 1; bus.ex_rd_i = 3; bus.id_rs1_i = 3; bus.id_rs1_use_i = 1;
      #1;
      chk_out("rst_lu", 3'b110, 4'b0100, 0, 0);
      cyc();
      chk("rst_lu_stall", {32'd0, bus.stall_cnt_o}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
